udma_adc_rx_chbuf: RTL and testbench
====================================

UDMA_ADC_RX_CHBUF -- requirements
Module: udma_adc_rx_chbuf

Interface
REQ-001 Parameter ADC_DATA_WIDTH, default 32: width of the ADC sample word, at most 32.
REQ-002 Parameter ADC_NUM_CHS, default 8: number of uDMA RX channels, at least 1.
REQ-003 Parameter CH_ID_LSB, default 28: LSB of the channel-ID field in the sample.
REQ-004 Parameter CH_ID_WIDTH, default 4: width of the channel-ID field.
REQ-005 Parameter FIFO_DEPTH, default 4: entries per channel FIFO, a power of 2 and at least 2.
REQ-006 Port sys_clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 Port rst_i, input, 1 bit: synchronous active-high reset.
REQ-008 Port adc_rx_valid_async_i, input, 1 bit: asynchronous ADC sample strobe.
REQ-009 Port adc_rx_data_i, input, ADC_DATA_WIDTH bits: ADC sample; stable while the strobe is high.
REQ-010 Port cfg_single_ch_mode_i, input, 1 bit: route every sample to channel 0.
REQ-011 Port cfg_strip_id_i, input, 1 bit: zero the channel-ID field in stored words.
REQ-012 Port cfg_ch_en_i, input, ADC_NUM_CHS bits: per-channel accept enable.
REQ-013 Port cfg_ch_clr_i, input, ADC_NUM_CHS bits: per-channel flush and statistics clear, pulse.
REQ-014 Port data_rx_o, output, ADC_NUM_CHS x 32 bits: per-channel head word, zero-extended.
REQ-015 Port data_rx_valid_o, output, ADC_NUM_CHS bits: channel FIFO not empty.
REQ-016 Port data_rx_ready_i, input, ADC_NUM_CHS bits: uDMA pop request.
REQ-017 Port ovf_o, output, ADC_NUM_CHS bits: sticky overflow flag per channel.
REQ-018 Port drop_cnt_o, output, ADC_NUM_CHS x 8 bits: dropped-sample count per channel.
REQ-019 Port bad_id_o, output, 1 bit: sticky flag for a sample with channel ID >= ADC_NUM_CHS.

Function
REQ-020 Strobe sampled by 3 flops sync[2:0]; edge = sync[1] & ~sync[2].
REQ-021 On an edge cycle, target channel = 0 if cfg_single_ch_mode_i or ADC_NUM_CHS==1, else the ID field of adc_rx_data_i.
REQ-022 Edge with target enabled, not full (or popped same cycle), no clear -> write sample into that FIFO at end of the edge cycle.
REQ-023 Stored word = adc_rx_data_i, with bits [CH_ID_LSB+CH_ID_WIDTH-1:CH_ID_LSB] zeroed when cfg_strip_id_i=1, then zero-extended to 32 bits.
REQ-024 Latency: strobe first sampled high at edge k -> data_rx_valid_o high after edge k+2, valid through the following cycle.
REQ-025 First-word fall-through: data_rx_o shows the head entry whenever data_rx_valid_o=1; data_rx_o is don't-care otherwise.
REQ-026 Pop occurs on data_rx_valid_o & data_rx_ready_i; ready while empty has no effect.
REQ-027 Full FIFO + edge + same-cycle pop -> push and pop both occur, occupancy unchanged, no overflow.
REQ-028 Full FIFO + edge + no pop -> sample dropped, ovf_o set, drop_cnt_o incremented.
REQ-029 drop_cnt_o saturates at 255.
REQ-030 Edge targeting a disabled channel -> sample dropped silently; no flag, no count.
REQ-031 ID >= ADC_NUM_CHS in multi-channel mode -> sample dropped, bad_id_o set.
REQ-032 cfg_ch_clr_i[i] -> FIFO i emptied, ovf_o[i] cleared, drop_cnt_o[i] cleared at the next edge.
REQ-033 Clear wins over a same-cycle push or pop on that channel; the sample is lost and not counted.
REQ-034 bad_id_o is cleared only by reset.
REQ-035 Pointers are log2(FIFO_DEPTH)+1 bits wide.
REQ-036 Full and empty are decoded from the pointer MSB; pointers wrap naturally.

Reset
REQ-037 rst_i high at a clock edge -> sync flops 0, all FIFOs empty, data_rx_valid_o=0, ovf_o=0, drop_cnt_o=0, bad_id_o=0.
REQ-038 Reset asserted mid-stream discards stored and in-flight samples.
REQ-039 After reset release, the first edge requires the strobe to be seen low, then high.
REQ-040 FIFO storage arrays are not reset.

Structure
REQ-041 Package udma_adc_rx_pkg holds the drop-counter width constant (8) and the pointer-width function.
REQ-042 Sub-module udma_adc_rx_ch_fifo holds one channel's FIFO plus its ovf and drop counter.
REQ-043 The top instantiates ADC_NUM_CHS copies of udma_adc_rx_ch_fifo via generate.

Verification
REQ-044 Single-channel mode, strobe pulse with data 0x3000_00AB -> ch0 valid 3 edges later, data 0x3000_00AB; strip_id=1 gives 0x0000_00AB.
REQ-045 Multi-channel, samples with IDs 2,5,2 and ready=0 -> ch2 holds 2 entries and ch5 holds 1, order preserved.
REQ-046 Ch1, depth 4, 6 samples, ready=0 -> 4 stored, ovf_o[1]=1, drop_cnt_o[1]=2; then clr -> empty, 0, 0.
REQ-047 Ch3 full with ready=1 on the same cycle as an edge -> still full, no overflow, FIFO order intact.
REQ-048 Sample with ID 9 -> bad_id_o=1, no channel valid; 300 overflows on one channel -> drop_cnt_o=255.
REQ-049 Reset asserted with 3 entries queued -> all data_rx_valid_o=0 on the next edge.

Source files
------------

// File: rtl/udma_adc_rx_pkg.sv
// Shared constants and helpers for the ADC RX channel buffer.
package udma_adc_rx_pkg;

    localparam int DROP_CNT_WIDTH = 8;

    // One extra MSB distinguishes full from empty when the index bits match.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/udma_adc_rx_ch_fifo.sv
// One channel: first-word-fall-through FIFO with sticky overflow flag and
// saturating dropped-sample counter.
module udma_adc_rx_ch_fifo
    import udma_adc_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic                      push,
    input  logic [31:0]               push_data,
    input  logic                      ready,
    input  logic                      clr,
    output logic [31:0]               data,
    output logic                      valid,
    output logic                      ovf,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

    localparam int PW = ptr_width(FIFO_DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [DROP_CNT_WIDTH-1:0] CNT_ONE = {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [31:0]               mem [FIFO_DEPTH];
    logic [PW-1:0]             wr_ptr_reg, rd_ptr_reg;
    logic                      ovf_reg;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_reg;

    logic empty, full, do_pop, do_push, do_drop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    // A clear on this channel overrides any push or pop in the same cycle.
    assign do_pop  = ~empty & ready & ~clr;
    assign do_push = push & ~clr & (~full | do_pop);
    assign do_drop = push & ~clr & full & ~do_pop;

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            ovf_reg      <= 1'b0;
            drop_cnt_reg <= '0;
        end else if (clr) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            ovf_reg      <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            if (do_drop) begin
                ovf_reg <= 1'b1;
                if (drop_cnt_reg != '1)
                    drop_cnt_reg <= drop_cnt_reg + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    assign data     = mem[rd_ptr_reg[AW-1:0]];
    assign valid    = ~empty;
    assign ovf      = ovf_reg;
    assign drop_cnt = drop_cnt_reg;

endmodule

// File: rtl/udma_adc_rx_chbuf.sv
// ADC sample receiver: synchronises the async strobe, routes each sample by
// its channel-ID field and buffers it in a per-channel uDMA RX FIFO.
module udma_adc_rx_chbuf
    import udma_adc_rx_pkg::*;
#(
    parameter int ADC_DATA_WIDTH = 32,
    parameter int ADC_NUM_CHS    = 8,
    parameter int CH_ID_LSB      = 28,
    parameter int CH_ID_WIDTH    = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                                  sys_clk_i,
    input  logic                                  rst_i,
    input  logic                                  adc_rx_valid_async_i,
    input  logic [ADC_DATA_WIDTH-1:0]             adc_rx_data_i,
    input  logic                                  cfg_single_ch_mode_i,
    input  logic                                  cfg_strip_id_i,
    input  logic [ADC_NUM_CHS-1:0]                cfg_ch_en_i,
    input  logic [ADC_NUM_CHS-1:0]                cfg_ch_clr_i,
    output logic [ADC_NUM_CHS*32-1:0]             data_rx_o,
    output logic [ADC_NUM_CHS-1:0]                data_rx_valid_o,
    input  logic [ADC_NUM_CHS-1:0]                data_rx_ready_i,
    output logic [ADC_NUM_CHS-1:0]                ovf_o,
    output logic [ADC_NUM_CHS*DROP_CNT_WIDTH-1:0] drop_cnt_o,
    output logic                                  bad_id_o
);

    localparam logic [31:0] ID_MASK = ((32'd1 << CH_ID_WIDTH) - 32'd1) << CH_ID_LSB;

    logic [2:0]  sync_reg;
    logic [2:0]  prime_reg;
    logic        bad_id_reg;
    logic        rx_edge, multi_ch, bad_id;
    logic [31:0] id_ext, target_ch, store_word;

    // prime_reg marks sync stages that hold a real post-reset sample, so a
    // strobe already high at reset release never produces an edge.
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            sync_reg   <= '0;
            prime_reg  <= '0;
            bad_id_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[1:0], adc_rx_valid_async_i};
            prime_reg <= {prime_reg[1:0], 1'b1};
            if (bad_id)
                bad_id_reg <= 1'b1;
        end
    end

    assign rx_edge    = sync_reg[1] & ~sync_reg[2] & prime_reg[2];
    assign multi_ch   = (ADC_NUM_CHS > 1) && !cfg_single_ch_mode_i;
    assign id_ext     = 32'(adc_rx_data_i[CH_ID_LSB +: CH_ID_WIDTH]);
    assign target_ch  = multi_ch ? id_ext : 32'd0;
    assign bad_id     = rx_edge & multi_ch & (id_ext >= 32'(ADC_NUM_CHS));
    assign store_word = 32'(adc_rx_data_i) & ~(cfg_strip_id_i ? ID_MASK : 32'd0);
    assign bad_id_o   = bad_id_reg;

    generate
        for (genvar gi = 0; gi < ADC_NUM_CHS; gi++) begin : g_ch
            logic push;
            assign push = rx_edge & ~bad_id & cfg_ch_en_i[gi] & (target_ch == 32'(gi));

            udma_adc_rx_ch_fifo #(
                .FIFO_DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk       (sys_clk_i),
                .srst      (rst_i),
                .push      (push),
                .push_data (store_word),
                .ready     (data_rx_ready_i[gi]),
                .clr       (cfg_ch_clr_i[gi]),
                .data      (data_rx_o[gi*32 +: 32]),
                .valid     (data_rx_valid_o[gi]),
                .ovf       (ovf_o[gi]),
                .drop_cnt  (drop_cnt_o[gi*DROP_CNT_WIDTH +: DROP_CNT_WIDTH])
            );
        end
    endgenerate

endmodule

// File: tb/tb_udma_adc_rx_chbuf.sv
// Directed bench with a per-channel expected-word scoreboard for udma_adc_rx_chbuf.
module tb_udma_adc_rx_chbuf;

    logic          clk = 1'b0;
    logic          rst;
    logic          strobe;
    logic [31:0]   adc_data;
    logic          single_mode;
    logic          strip;
    logic [7:0]    ch_en;
    logic [7:0]    ch_clr;
    logic [255:0]  data_rx_o;
    logic [7:0]    data_rx_valid_o;
    logic [7:0]    ready;
    logic [7:0]    ovf_o;
    logic [63:0]   drop_cnt_o;
    logic          bad_id_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q [8][$];
    bit   [7:0]  ovf_m;
    int          drop_m [8];
    bit          bad_m;

    always #5 clk = ~clk;

    udma_adc_rx_chbuf dut (
        .sys_clk_i            (clk),
        .rst_i                (rst),
        .adc_rx_valid_async_i (strobe),
        .adc_rx_data_i        (adc_data),
        .cfg_single_ch_mode_i (single_mode),
        .cfg_strip_id_i       (strip),
        .cfg_ch_en_i          (ch_en),
        .cfg_ch_clr_i         (ch_clr),
        .data_rx_o            (data_rx_o),
        .data_rx_valid_o      (data_rx_valid_o),
        .data_rx_ready_i      (ready),
        .ovf_o                (ovf_o),
        .drop_cnt_o           (drop_cnt_o),
        .bad_id_o             (bad_id_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear_all();
        for (int i = 0; i < 8; i++) begin
            exp_q[i].delete();
            drop_m[i] = 0;
        end
        ovf_m = '0;
        bad_m = 1'b0;
    endfunction

    // Reference routing/buffering decision for one strobed sample.
    function automatic void model_push(input logic [31:0] d);
        int ch;
        logic [31:0] w;
        ch = single_mode ? 0 : int'(d[31:28]);
        w  = strip ? (d & 32'h0FFF_FFFF) : d;
        if (!single_mode && ch >= 8)
            bad_m = 1'b1;
        else if (ch_en[ch]) begin
            if (exp_q[ch].size() < 4)
                exp_q[ch].push_back(w);
            else begin
                ovf_m[ch] = 1'b1;
                if (drop_m[ch] < 255)
                    drop_m[ch]++;
            end
        end
    endfunction

    task automatic compare_state(input string tag);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s valid[%0d]", tag, i), 32'(data_rx_valid_o[i]), 32'(exp_q[i].size() != 0));
            check($sformatf("%s ovf[%0d]", tag, i), 32'(ovf_o[i]), 32'(ovf_m[i]));
            check($sformatf("%s drop[%0d]", tag, i), 32'(drop_cnt_o[i*8 +: 8]), 32'(drop_m[i]));
        end
        check($sformatf("%s bad_id", tag), 32'(bad_id_o), 32'(bad_m));
    endtask

    // Called at a negedge; strobe high 3 cycles then low 3 cycles.
    task automatic send(input logic [31:0] d);
        model_push(d);
        adc_data = d;
        strobe   = 1'b1;
        repeat (3) @(negedge clk);
        strobe = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Same as send, but pops channel ch during the write cycle.
    task automatic send_pop(input logic [31:0] d, input int ch);
        logic [31:0] head;
        adc_data = d;
        strobe   = 1'b1;
        repeat (2) @(negedge clk);
        head = exp_q[ch].pop_front();
        check($sformatf("pop-at-edge head ch%0d", ch), data_rx_o[ch*32 +: 32], head);
        model_push(d);
        ready[ch] = 1'b1;
        @(negedge clk);
        ready[ch] = 1'b0;
        strobe    = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic drain(input int ch);
        logic [31:0] exp;
        while (exp_q[ch].size() > 0) begin
            exp = exp_q[ch].pop_front();
            check($sformatf("drain valid ch%0d", ch), 32'(data_rx_valid_o[ch]), 32'd1);
            check($sformatf("drain data ch%0d", ch), data_rx_o[ch*32 +: 32], exp);
            $display("pop ch%0d data=0x%08h expected=0x%08h", ch, data_rx_o[ch*32 +: 32], exp);
            ready[ch] = 1'b1;
            @(negedge clk);
            ready[ch] = 1'b0;
        end
        check($sformatf("drained empty ch%0d", ch), 32'(data_rx_valid_o[ch]), 32'd0);
    endtask

    task automatic clear_ch(input int ch);
        ch_clr[ch] = 1'b1;
        @(negedge clk);
        ch_clr[ch] = 1'b0;
        exp_q[ch].delete();
        ovf_m[ch]  = 1'b0;
        drop_m[ch] = 0;
    endtask

    initial begin
        rst = 1'b1; strobe = 1'b0; adc_data = '0; single_mode = 1'b1; strip = 1'b0;
        ch_en = 8'hFF; ch_clr = '0; ready = '0;
        model_clear_all();
        repeat (3) @(negedge clk);
        compare_state("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Latency: strobe first sampled at edge k, valid after edge k+2.
        model_push(32'h3000_00AB);
        adc_data = 32'h3000_00AB;
        strobe   = 1'b1;
        @(negedge clk);
        check("latency k", 32'(data_rx_valid_o[0]), 32'd0);
        @(negedge clk);
        check("latency k+1", 32'(data_rx_valid_o[0]), 32'd0);
        @(negedge clk);
        check("latency k+2", 32'(data_rx_valid_o[0]), 32'd1);
        strobe = 1'b0;
        repeat (3) @(negedge clk);
        drain(0);

        strip = 1'b1;
        send(32'h3000_00AB);
        drain(0);
        strip = 1'b0;

        // Multi-channel routing with order preserved.
        single_mode = 1'b0;
        send(32'h2000_0001);
        send(32'h5000_0002);
        send(32'h2000_0003);
        compare_state("route");
        drain(2);
        drain(5);

        // Overflow on ch1 then clear.
        for (int i = 0; i < 6; i++)
            send(32'h1000_0010 + 32'(i));
        compare_state("ovf ch1");
        check("ovf ch1 head", data_rx_o[32 +: 32], exp_q[1][0]);
        clear_ch(1);
        compare_state("clr ch1");

        // Full ch3 with a pop in the same cycle as the write.
        for (int i = 0; i < 4; i++)
            send(32'h3000_0030 + 32'(i));
        send_pop(32'h3000_0039, 3);
        compare_state("full pop ch3");
        drain(3);

        // Disabled channel drops silently.
        ch_en[4] = 1'b0;
        send(32'h4000_0044);
        compare_state("disabled ch4");
        ch_en[4] = 1'b1;

        // Out-of-range channel ID.
        send(32'h9000_0099);
        compare_state("bad id");

        // Drop counter saturation on ch6.
        for (int i = 0; i < 304; i++)
            send(32'h6000_0000 + 32'(i));
        compare_state("saturate ch6");
        clear_ch(6);

        // Reset mid-stream with queued entries and a strobe held high across it.
        for (int i = 0; i < 3; i++)
            send(32'h7000_0070 + 32'(i));
        compare_state("pre-reset");
        adc_data = 32'h7000_0077;
        strobe   = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        model_clear_all();
        check("reset valid", 32'(data_rx_valid_o), 32'd0);
        check("reset bad_id", 32'(bad_id_o), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        compare_state("held strobe after reset");
        strobe = 1'b0;
        repeat (3) @(negedge clk);
        send(32'h7000_0078);
        compare_state("post-reset");
        drain(7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
